// File: rtl/gen_bus_write_buffer.sv
// Purpose: posted-write buffer between the core's generic bus and the memory-side generic bus.
// Latency: stores are accepted with zero wait. A load issues mem_ren one cycle after it is requested.
// Backpressure: cpu_busy=1 while the buffer is full or drain_req is set (stores), or until the memory read completes (loads).
//
// Ports:
//   CLK, nRST                       clock; asynchronous active-high reset
//   cpu_addr/wdata/byte_en/ren/wen  CPU request side; requests are held until cpu_busy=0
//   cpu_rdata, cpu_busy             load data, and the completion indication (0 = request completes this cycle)
//   mem_addr/wdata/byte_en/ren/wen  memory request side; registered (Moore) outputs
//   mem_rdata, mem_busy             memory response (mem_busy=0 means the request completes this cycle)
//   drain_req                       blocks new stores and lets the buffer drain
//   empty                           no buffered entries and no memory store in flight
//   count                           number of valid entries
module gen_bus_write_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    input  logic [3:0]       cpu_byte_en,
    input  logic             cpu_ren,
    input  logic             cpu_wen,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_busy,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_byte_en,
    output logic             mem_ren,
    output logic             mem_wen,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_busy,
    input  logic             drain_req,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t             state;
    logic [31:0]        q_addr  [DEPTH];
    logic [31:0]        q_wdata [DEPTH];
    logic [3:0]         q_be    [DEPTH];
    logic [DEPTH-1:0]   q_vld;
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic [CNT_W-1:0]   count_q;

    logic push;
    logic pop;
    logic hit;
    logic load_req;

    // A full buffer refuses the store even if the head pops this cycle.
    assign push     = cpu_wen && !drain_req && (count_q < CNT_W'(DEPTH));
    assign pop      = (state == WRITE) && !mem_busy;
    // A store takes precedence over a simultaneous load request.
    assign load_req = cpu_ren && !cpu_wen;

    // Word-address match against every buffered entry, including the head
    // currently being written to memory. Byte enables are deliberately ignored.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_vld[i] && (q_addr[i][31:2] == cpu_addr[31:2])) begin
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        cpu_busy  = 1'b1;
        cpu_rdata = '0;
        if (cpu_wen) begin
            cpu_busy = !push;
        end else if (cpu_ren && (state == READ) && !mem_busy) begin
            cpu_busy  = 1'b0;
            cpu_rdata = mem_rdata;
        end
    end

    assign empty = (count_q == '0) && (state != WRITE);
    assign count = count_q;

    // Entry storage: no reset is needed because validity lives in q_vld.
    always_ff @(posedge CLK) begin
        if (push) begin
            q_addr[wptr]  <= cpu_addr;
            q_wdata[wptr] <= cpu_wdata;
            q_be[wptr]    <= cpu_byte_en;
        end
    end

    // Pointers, count and valid flags. Push and pop never address the same
    // slot: a pop implies a non-empty buffer, and a push implies one that is not full.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
            q_vld   <= '0;
        end else begin
            if (pop) begin
                q_vld[rptr] <= 1'b0;
                rptr        <= rptr + PTR_W'(1);
            end
            if (push) begin
                q_vld[wptr] <= 1'b1;
                wptr        <= wptr + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Memory-side sequencer. Every transaction returns to IDLE, which
    // guarantees one idle cycle between memory transactions and gives
    // non-hitting loads a chance to overtake pending stores.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state       <= IDLE;
            mem_ren     <= 1'b0;
            mem_wen     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_byte_en <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_req && !hit) begin
                        state       <= READ;
                        mem_ren     <= 1'b1;
                        mem_addr    <= cpu_addr;
                        mem_wdata   <= '0;
                        mem_byte_en <= cpu_byte_en;
                    end else if (count_q != '0) begin
                        state       <= WRITE;
                        mem_wen     <= 1'b1;
                        mem_addr    <= q_addr[rptr];
                        mem_wdata   <= q_wdata[rptr];
                        mem_byte_en <= q_be[rptr];
                    end
                end
                WRITE: begin
                    if (!mem_busy) begin
                        state       <= IDLE;
                        mem_wen     <= 1'b0;
                        mem_addr    <= '0;
                        mem_wdata   <= '0;
                        mem_byte_en <= '0;
                    end
                end
                READ: begin
                    if (!mem_busy) begin
                        state       <= IDLE;
                        mem_ren     <= 1'b0;
                        mem_addr    <= '0;
                        mem_byte_en <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_ren <= 1'b0;
                    mem_wen <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gen_bus_write_buffer.sv
module tb_gen_bus_write_buffer;
    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_byte_en;
    logic        cpu_ren, cpu_wen, cpu_busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_byte_en;
    logic        mem_ren, mem_wen, mem_busy;
    logic        drain_req, empty;
    logic [2:0]  count;

    gen_bus_write_buffer #(.DEPTH(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_byte_en(cpu_byte_en),
        .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
        .drain_req(drain_req), .empty(empty), .count(count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } txn_t;
    txn_t txq[$];
    logic track = 1'b0;
    int   maxcnt = 0;

    // Records every completed memory transaction, sampled mid low phase.
    always begin
        @(negedge CLK);
        #1;
        if (!nRST && !mem_busy) begin
            if (mem_wen) txq.push_back('{1'b1, mem_addr, mem_wdata, mem_byte_en});
            if (mem_ren) txq.push_back('{1'b0, mem_addr, 32'h0, 4'h0});
        end
        if (track && (int'(count) > maxcnt)) maxcnt = int'(count);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_txn(input string nm, input int idx, input logic w,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        checks++;
        if (idx >= txq.size()) begin
            fails++;
            $display("FAIL %s: transaction %0d missing (log size %0d)", nm, idx, txq.size());
        end else if (txq[idx].w !== w || txq[idx].a !== a ||
                     (w && (txq[idx].d !== d || txq[idx].be !== be))) begin
            fails++;
            $display("FAIL %s: got w=%b a=%h d=%h be=%h expected w=%b a=%h d=%h be=%h", nm,
                     txq[idx].w, txq[idx].a, txq[idx].d, txq[idx].be, w, a, d, be);
        end
    endtask

    // The caller sits at negedge+2 with a request held; returns in the completion cycle.
    task automatic wait_cpu(input string nm);
        int n = 0;
        while (cpu_busy && n < 30) begin
            @(negedge CLK);
            #2;
            n++;
        end
        chk({nm, " completes"}, 32'(cpu_busy), 32'h0);
    endtask

    task automatic wait_empty(input string nm);
        int n = 0;
        while (!empty && n < 40) begin
            @(negedge CLK);
            #2;
            n++;
        end
        chk({nm, " empty"}, 32'(empty), 32'h1);
    endtask

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic        mbusy;
        logic        e_busy;
        logic        e_mwen;
        logic [31:0] e_maddr;
        logic [2:0]  e_cnt;
        logic        e_empty;
    } vec_t;
    vec_t tbl[16];

    function automatic vec_t mk(input logic wen, input logic [31:0] addr, input logic mbusy,
                                input logic e_busy, input logic e_mwen, input logic [31:0] e_maddr,
                                input logic [2:0] e_cnt, input logic e_empty);
        vec_t v;
        v.wen = wen; v.addr = addr; v.mbusy = mbusy; v.e_busy = e_busy;
        v.e_mwen = e_mwen; v.e_maddr = e_maddr; v.e_cnt = e_cnt; v.e_empty = e_empty;
        return v;
    endfunction

    logic bad;

    initial begin
        // Fill to full with memory stalled, then drain in order.
        tbl[0]  = mk(1, 32'h00, 1, 0, 0, 32'h0,  3'd0, 1);
        tbl[1]  = mk(1, 32'h04, 1, 0, 0, 32'h0,  3'd1, 0);
        tbl[2]  = mk(1, 32'h08, 1, 0, 1, 32'h0,  3'd2, 0);
        tbl[3]  = mk(1, 32'h0C, 1, 0, 1, 32'h0,  3'd3, 0);
        tbl[4]  = mk(1, 32'h10, 1, 1, 1, 32'h0,  3'd4, 0);
        tbl[5]  = mk(1, 32'h10, 0, 1, 1, 32'h0,  3'd4, 0);
        tbl[6]  = mk(1, 32'h10, 1, 0, 0, 32'h0,  3'd3, 0);
        tbl[7]  = mk(0, 32'h00, 1, 1, 1, 32'h4,  3'd4, 0);
        tbl[8]  = mk(0, 32'h00, 0, 1, 1, 32'h4,  3'd4, 0);
        tbl[9]  = mk(0, 32'h00, 0, 1, 0, 32'h0,  3'd3, 0);
        tbl[10] = mk(0, 32'h00, 0, 1, 1, 32'h8,  3'd3, 0);
        tbl[11] = mk(0, 32'h00, 0, 1, 0, 32'h0,  3'd2, 0);
        tbl[12] = mk(0, 32'h00, 0, 1, 1, 32'hC,  3'd2, 0);
        tbl[13] = mk(0, 32'h00, 0, 1, 0, 32'h0,  3'd1, 0);
        tbl[14] = mk(0, 32'h00, 0, 1, 1, 32'h10, 3'd1, 0);
        tbl[15] = mk(0, 32'h00, 0, 1, 0, 32'h0,  3'd0, 1);

        nRST = 1'b1; cpu_addr = 0; cpu_wdata = 0; cpu_byte_en = 0; cpu_ren = 0; cpu_wen = 0;
        mem_rdata = 0; mem_busy = 1'b1; drain_req = 0;
        #2;
        chk("rst mem_wen", 32'(mem_wen), 0);
        chk("rst mem_ren", 32'(mem_ren), 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst cpu_busy", 32'(cpu_busy), 1);
        chk("rst cpu_rdata", cpu_rdata, 0);
        chk("rst empty", 32'(empty), 1);
        chk("rst count", 32'(count), 0);
        @(negedge CLK);
        nRST = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            cpu_wen = tbl[i].wen; cpu_addr = tbl[i].addr; cpu_wdata = tbl[i].addr ^ 32'hA5A50000;
            cpu_byte_en = 4'hF; mem_busy = tbl[i].mbusy;
            #2;
            chk($sformatf("v%0d cpu_busy", i), 32'(cpu_busy), 32'(tbl[i].e_busy));
            chk($sformatf("v%0d mem_wen", i), 32'(mem_wen), 32'(tbl[i].e_mwen));
            chk($sformatf("v%0d mem_ren", i), 32'(mem_ren), 0);
            if (tbl[i].e_mwen) begin
                chk($sformatf("v%0d mem_addr", i), mem_addr, tbl[i].e_maddr);
                chk($sformatf("v%0d mem_wdata", i), mem_wdata, tbl[i].e_maddr ^ 32'hA5A50000);
            end
            chk($sformatf("v%0d count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d empty", i), 32'(empty), 32'(tbl[i].e_empty));
        end

        // Load hitting a buffered store waits for that store.
        @(negedge CLK);
        txq.delete();
        mem_busy = 0; cpu_wen = 1; cpu_addr = 32'h100; cpu_wdata = 32'hDEADBEEF; cpu_byte_en = 4'hF;
        #2 chk("hit store accept", 32'(cpu_busy), 0);
        @(negedge CLK);
        cpu_wen = 0; cpu_ren = 1; mem_rdata = 32'hCAFE0001;
        #2;
        wait_cpu("hit load");
        chk("hit rdata", cpu_rdata, 32'hCAFE0001);
        chk("hit count", 32'(count), 0);
        @(negedge CLK);
        cpu_ren = 0;
        #2;
        chk_txn("hit order0", 0, 1, 32'h100, 32'hDEADBEEF, 4'hF);
        chk_txn("hit order1", 1, 0, 32'h100, 0, 0);

        // A non-hitting load overtakes pending stores.
        txq.delete();
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            cpu_wen = 1; cpu_addr = (i == 0) ? 32'hF0 : 32'h100 + 32'(4 * (i - 1));
            cpu_wdata = 32'h5000 + 32'(i); cpu_byte_en = 4'hF;
        end
        @(negedge CLK);
        cpu_wen = 0; cpu_ren = 1; cpu_addr = 32'h200; mem_busy = 0; mem_rdata = 32'h12345678;
        #2;
        wait_cpu("bypass load");
        chk("bypass rdata", cpu_rdata, 32'h12345678);
        @(negedge CLK);
        cpu_ren = 0;
        #2;
        wait_empty("bypass");
        chk("bypass log size", 32'(txq.size()), 4);
        chk_txn("bypass t0", 0, 1, 32'hF0, 32'h5000, 4'hF);
        chk_txn("bypass t1", 1, 0, 32'h200, 0, 0);
        chk_txn("bypass t2", 2, 1, 32'h100, 32'h5001, 4'hF);
        chk_txn("bypass t3", 3, 1, 32'h104, 32'h5002, 4'hF);

        // Drain with partial byte enables; new stores stall meanwhile.
        txq.delete();
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            cpu_wen = 1; cpu_addr = 32'h300 + 32'(4 * i); cpu_wdata = 32'h7000 + 32'(i);
            cpu_byte_en = (i == 0) ? 4'h1 : (i == 1) ? 4'h3 : 4'hC;
        end
        @(negedge CLK);
        drain_req = 1; cpu_addr = 32'h30C; cpu_wdata = 32'h7003; cpu_byte_en = 4'hF; mem_busy = 0;
        #2;
        bad = 0;
        for (int n = 0; n < 40 && !empty; n++) begin
            if (!cpu_busy) bad = 1;
            @(negedge CLK);
            #2;
        end
        chk("drain store stalled", 32'(bad), 0);
        chk("drain empty", 32'(empty), 1);
        chk("drain empty after 3rd", 32'(txq.size()), 3);
        chk_txn("drain t0", 0, 1, 32'h300, 32'h7000, 4'h1);
        chk_txn("drain t1", 1, 1, 32'h304, 32'h7001, 4'h3);
        chk_txn("drain t2", 2, 1, 32'h308, 32'h7002, 4'hC);
        @(negedge CLK);
        drain_req = 0;
        #2 chk("post-drain accept", 32'(cpu_busy), 0);
        @(negedge CLK);
        cpu_wen = 0;
        #2;
        wait_empty("post-drain");
        chk_txn("post-drain t3", 3, 1, 32'h30C, 32'h7003, 4'hF);

        // Reset while a store is in flight.
        mem_busy = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            cpu_wen = 1; cpu_addr = 32'h400 + 32'(4 * i); cpu_wdata = 32'h9000; cpu_byte_en = 4'hF;
        end
        @(negedge CLK);
        cpu_wen = 0;
        #2;
        chk("pre-rst mem_wen", 32'(mem_wen), 1);
        chk("pre-rst count", 32'(count), 2);
        #1 nRST = 1;
        #1;
        chk("mid-rst mem_wen", 32'(mem_wen), 0);
        chk("mid-rst count", 32'(count), 0);
        chk("mid-rst empty", 32'(empty), 1);
        txq.delete();
        @(negedge CLK);
        nRST = 0; mem_busy = 0;
        bad = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge CLK);
            #2;
            if (mem_wen || mem_ren) bad = 1;
        end
        chk("post-rst no stale txn", 32'(bad), 0);
        chk("post-rst log size", 32'(txq.size()), 0);

        // Alternating store/load with memory always ready.
        txq.delete();
        maxcnt = 0; track = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            cpu_wen = 1; cpu_addr = 32'h500 + 32'(16 * i); cpu_wdata = 32'hB000 + 32'(i); cpu_byte_en = 4'hF;
            #2;
            wait_cpu($sformatf("alt store%0d", i));
            @(negedge CLK);
            cpu_wen = 0;
            @(negedge CLK);
            cpu_ren = 1; cpu_addr = 32'h508 + 32'(16 * i); mem_rdata = 32'h11110000 + 32'(i);
            #2;
            wait_cpu($sformatf("alt load%0d", i));
            chk($sformatf("alt rdata%0d", i), cpu_rdata, 32'h11110000 + 32'(i));
            @(negedge CLK);
            cpu_ren = 0;
        end
        #2;
        wait_empty("alt");
        track = 0;
        chk("alt max count", 32'(maxcnt), 1);
        chk("alt log size", 32'(txq.size()), 8);
        for (int i = 0; i < 4; i++) begin
            chk_txn($sformatf("alt w%0d", i), 2 * i, 1, 32'h500 + 32'(16 * i), 32'hB000 + 32'(i), 4'hF);
            chk_txn($sformatf("alt r%0d", i), 2 * i + 1, 0, 32'h508 + 32'(16 * i), 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
